// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared constants and the sequencer state encoding for the
//            32-bit sequential restoring divider control block.
// Contents : DIV_WIDTH  - operand width (matches the Remainder block)
//            DIV_ITERS  - divide iterations after the load cycle
//            CNT_W      - width of the iteration counter
//            state_t    - IDLE / CLEAR / LOAD / ITER / DONE
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        ITER  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_control_if.sv
`default_nettype none
// ============================================================================
// Module   : div_control_if
// Purpose  : Request/response bundle between a divide requester and the
//            div_control sequencer.
// Signals  : start, dividend_in, divisor_in   - request (master -> slave)
//            busy, done, Quotient, Remainder_q,
//            div_by_zero                      - status/result (slave -> master)
// Modports : master - requester side; slave - div_control side
// Revision : 1.0 - initial release
// ============================================================================
interface div_control_if;
    import div_pkg::*;

    logic                 start;
    logic [DIV_WIDTH-1:0] dividend_in;
    logic [DIV_WIDTH-1:0] divisor_in;
    logic                 busy;
    logic                 done;
    logic [DIV_WIDTH-1:0] Quotient;
    logic [DIV_WIDTH-1:0] Remainder_q;
    logic                 div_by_zero;

    modport master (
        output start, dividend_in, divisor_in,
        input  busy, done, Quotient, Remainder_q, div_by_zero
    );

    modport slave (
        input  start, dividend_in, divisor_in,
        output busy, done, Quotient, Remainder_q, div_by_zero
    );

endinterface
`default_nettype wire

// File: rtl/div_iter_counter.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_counter
// Purpose  : Iteration counter for the divide sequencer. Cleared to zero,
//            advanced by one per enabled cycle, with a terminal-count flag
//            that is high while the count equals ITERS-1.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            clear     - synchronous clear (priority over en)
//            en        - count enable
//            tc        - terminal count (cnt == ITERS-1)
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_counter
    import div_pkg::*;
#(
    parameter int ITERS = DIV_ITERS
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic clear,
    input  wire logic en,
    output logic      tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(ITERS - 1));

endmodule
`default_nettype wire

// File: rtl/div_control.sv
`default_nettype none
// ============================================================================
// Module   : div_control
// Purpose  : Sequencer and operand/result stage for the 32-bit sequential
//            restoring divider, placed directly upstream of the Remainder
//            register block.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            bus (slave)   - start/operands in; busy, done, Quotient,
//                            Remainder_q, div_by_zero out
//            counting      - Remainder.counting
//            quotient_in   - Remainder.Quotient_out
//            remainder_in  - Remainder.Remainder_out
//            rem_rst       - Remainder.rst (rst OR state==CLEAR)
//            run           - Remainder.run
//            Dividend      - Remainder.Dividend (latched dividend)
//            Divisor       - subtract-ALU operand (latched divisor)
// Revision : 1.0 - initial release
// ============================================================================
module div_control
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITERS = WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    div_control_if.slave          bus,
    input  wire logic             counting,
    input  wire logic [WIDTH-1:0] quotient_in,
    input  wire logic [WIDTH-1:0] remainder_in,
    output logic                  rem_rst,
    output logic                  run,
    output logic [WIDTH-1:0]      Dividend,
    output logic [WIDTH-1:0]      Divisor
);

    state_t state;
    logic   tc;

    div_iter_counter #(
        .ITERS (ITERS)
    ) u_iter_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (state == LOAD),
        .en    (state == ITER),
        .tc    (tc)
    );

    // Remainder is cleared by system reset and for the whole CLEAR cycle.
    assign rem_rst = rst | (state == CLEAR);

    // The last Remainder update happens on the edge that leaves ITER, so the
    // results are captured while in DONE. done is raised on that same edge,
    // which keeps the pulse aligned with the freshly captured results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            run             <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.Quotient    <= '0;
            bus.Remainder_q <= '0;
            bus.div_by_zero <= 1'b0;
            Dividend        <= '0;
            Divisor         <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    run <= 1'b0;
                    if (bus.start) begin
                        Dividend <= bus.dividend_in;
                        Divisor  <= bus.divisor_in;
                        bus.busy <= 1'b1;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    run   <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    run   <= 1'b1;
                    state <= ITER;
                end
                ITER: begin
                    if (!counting) begin
                        // Remainder fell out of step: abandon without done.
                        run      <= 1'b0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (tc) begin
                        run   <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.Quotient    <= quotient_in;
                    bus.Remainder_q <= remainder_in;
                    bus.div_by_zero <= (Divisor == '0);
                    bus.done        <= 1'b1;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: begin
                    run      <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_control
// Purpose  : Self-checking bench for div_control with a behavioural model of
//            the Remainder register block closing the loop.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_control;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rem_rst;
    logic        run;
    logic [31:0] dividend_o;
    logic [31:0] divisor_o;
    logic        force_low;
    logic        counting;

    div_control_if bus ();

    // Remainder block model
    logic        m_loaded;
    logic        m_counting;
    logic [31:0] m_r;
    logic [31:0] m_q;
    int          m_it;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   done_seen = 0;
    int   busy_run = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign counting = m_counting & ~force_low;

    div_control dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .counting     (counting),
        .quotient_in  (m_q),
        .remainder_in (m_r),
        .rem_rst      (rem_rst),
        .run          (run),
        .Dividend     (dividend_o),
        .Divisor      (divisor_o)
    );

    function automatic logic [63:0] iter_step(logic [31:0] r, logic [31:0] q, logic [31:0] d);
        logic [32:0] t;
        t = {r, q[31]};
        if (t >= {1'b0, d})
            return {t[31:0] - d, q[30:0], 1'b1};
        else
            return {t[31:0], q[30:0], 1'b0};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rem_rst) begin
            m_loaded   <= 1'b0;
            m_counting <= 1'b0;
            m_r        <= '0;
            m_q        <= '0;
            m_it       <= 0;
        end else if (run) begin
            if (!m_loaded) begin
                m_loaded   <= 1'b1;
                m_counting <= 1'b1;
                m_r        <= '0;
                m_q        <= dividend_o;
                m_it       <= 0;
            end else if (m_counting) begin
                {m_r, m_q} <= iter_step(m_r, m_q, divisor_o);
                m_it       <= m_it + 1;
                if (m_it == 31) m_counting <= 1'b0;
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
        end else if (bus.busy) begin
            busy_run++;
        end else begin
            if (bus.done) begin
                chk("busy_cycles", busy_run, 35);
                chk("done_latency", cyc - accept_cyc, 35);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no done (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", bus.Quotient, e.q);
                    chk("remainder", bus.Remainder_q, e.r);
                    chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
                end
                done_seen++;
            end
            busy_run = 0;
        end
    end

    task automatic wait_done(int n0);
        for (int i = 0; i < 100 && done_seen == n0; i++) begin
            @(posedge clk);
            #1;
        end
        if (done_seen == n0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done, expected done within 100 cycles");
        end
    endtask

    task automatic start_op(logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.dividend_in = a;
        bus.divisor_in  = b;
        @(posedge clk);
        #1 accept_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_div(logic [31:0] a, logic [31:0] b, logic [31:0] q, logic [31:0] r, logic dbz);
        int n0;
        n0 = done_seen;
        sb.push_back('{q: q, r: r, dbz: dbz});
        start_op(a, b);
        wait_done(n0);
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 0);
        chk({tag, "_done"}, {31'b0, bus.done}, 0);
        chk({tag, "_quot"}, bus.Quotient, 0);
        chk({tag, "_rem"}, bus.Remainder_q, 0);
        chk({tag, "_dbz"}, {31'b0, bus.div_by_zero}, 0);
        chk({tag, "_run"}, {31'b0, run}, 0);
        chk({tag, "_dividend"}, dividend_o, 0);
        chk({tag, "_divisor"}, divisor_o, 0);
    endtask

    initial begin
        vec_t        vecs[6];
        logic [31:0] ra, rb;
        int          n0;

        vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2,          dbz: 1'b0};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'h0001_0000,  q: 32'h0000_FFFF,  r: 32'h0000_FFFF,  dbz: 1'b0};
        vecs[2] = '{a: 32'd5,          b: 32'd9,          q: 32'd0,          r: 32'd5,          dbz: 1'b0};
        vecs[3] = '{a: 32'h1234_5678,  b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'h1234_5678,  dbz: 1'b1};
        vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0,          dbz: 1'b0};
        vecs[5] = '{a: 32'h8000_0000,  b: 32'd1,          q: 32'h8000_0000,  r: 32'd0,          dbz: 1'b0};

        rst             = 1'b1;
        force_low       = 1'b0;
        bus.start       = 1'b0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rem_rst_in_reset", {31'b0, rem_rst}, 1);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rem_rst_after_reset", {31'b0, rem_rst}, 0);

        // Directed vectors
        for (int i = 0; i < 6; i++)
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);

        // Random operands, expectations from native division
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == 0) rb = 32'd3;
            run_div(ra, rb, ra / rb, ra % rb, 1'b0);
        end

        // Start while busy is ignored; previous results held until completion
        run_div(32'd81, 32'd9, 32'd9, 32'd0, 1'b0);
        n0 = done_seen;
        sb.push_back('{q: 32'd14, r: 32'd2, dbz: 1'b0});
        start_op(32'd100, 32'd7);
        repeat (8) @(negedge clk);
        bus.start       = 1'b1;
        bus.dividend_in = 32'd50;
        bus.divisor_in  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_hold_dividend", dividend_o, 32'd100);
        chk("busy_hold_divisor", divisor_o, 32'd7);
        chk("busy_hold_quotient", bus.Quotient, 32'd9);
        wait_done(n0);
        repeat (50) @(negedge clk);
        chk("no_second_done", done_seen - n0, 1);

        // Reset mid-operation
        start_op(32'd100, 32'd7);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        #1 chk("rem_rst_mid_reset", {31'b0, rem_rst}, 1);
        @(posedge clk);
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd81, 32'd9, 32'd9, 32'd0, 1'b0);

        // Counting drops during ITER: abandon without done
        n0 = done_seen;
        start_op(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        force_low = 1'b1;
        @(negedge clk);
        force_low = 1'b0;
        chk("proto_err_busy", {31'b0, bus.busy}, 0);
        chk("proto_err_run", {31'b0, run}, 0);
        repeat (50) @(negedge clk);
        chk("proto_err_no_done", done_seen - n0, 0);
        chk("proto_err_hold_q", bus.Quotient, 32'd9);

        // Back-to-back with start held high; operands latched only in IDLE
        n0 = done_seen;
        sb.push_back('{q: 32'd14, r: 32'd2, dbz: 1'b0});
        @(negedge clk);
        bus.start       = 1'b1;
        bus.dividend_in = 32'd100;
        bus.divisor_in  = 32'd7;
        @(posedge clk);
        #1 accept_cyc = cyc;
        @(negedge clk);
        bus.dividend_in = 32'd50;
        bus.divisor_in  = 32'd3;
        sb.push_back('{q: 32'd16, r: 32'd2, dbz: 1'b0});
        #1 chk("b2b_hold_dividend0", dividend_o, 32'd100);
        wait_done(n0);
        accept_cyc = cyc;
        @(negedge clk);
        bus.dividend_in = 32'd81;
        bus.divisor_in  = 32'd9;
        sb.push_back('{q: 32'd9, r: 32'd0, dbz: 1'b0});
        #1 chk("b2b_hold_dividend1", dividend_o, 32'd50);
        wait_done(n0 + 1);
        accept_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        #1 chk("b2b_hold_dividend2", dividend_o, 32'd81);
        wait_done(n0 + 2);
        repeat (45) @(negedge clk);
        chk("b2b_done_count", done_seen - n0, 3);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
